// File: rtl/alu_pkg.sv
// Shared encodings for the ALU operation classes, sub-operation selects and result bundle.
// Pure declarations: no logic, no latency, no flow control.
// Used by the ALU decode and the shifter so both agree on every code point.
package alu_pkg;

    localparam int W = 8;

    // Operation classes; OP[2]=1 is reserved and falls through to pass-A.
    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_LOGIC = 3'b001;
    localparam logic [2:0] OP_ORSUB = 3'b010;
    localparam logic [2:0] OP_SHIFT = 3'b011;

    // OP_ADD sub-operations (F=1x behaves as plain add).
    localparam logic [1:0] F_ADD   = 2'b00;
    localparam logic [1:0] F_ADC   = 2'b01;

    // OP_LOGIC sub-operations.
    localparam logic [1:0] F_AND   = 2'b00;
    localparam logic [1:0] F_XOR   = 2'b01;
    localparam logic [1:0] F_NOT   = 2'b10;
    localparam logic [1:0] F_PASSB = 2'b11;

    // OP_ORSUB sub-operations.
    localparam logic [1:0] F_OR    = 2'b00;
    localparam logic [1:0] F_SUB   = 2'b01;
    localparam logic [1:0] F_SLT   = 2'b10;
    localparam logic [1:0] F_SEQ   = 2'b11;

    // OP_SHIFT sub-operations.
    localparam logic [1:0] F_SLL   = 2'b00;
    localparam logic [1:0] F_SRL   = 2'b01;
    localparam logic [1:0] F_SRA   = 2'b10;
    localparam logic [1:0] F_ROL   = 2'b11;

    typedef struct packed {
        logic [W-1:0] res;
        logic         carry;
    } alu_res_t;

    // Widen a 1-bit predicate to a full-width 0/1 result.
    function automatic logic [W-1:0] bool_to_word(input logic b);
        return {{(W-1){1'b0}}, b};
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Logical/arithmetic shifts and left rotate of an 8-bit operand.
// Latency: combinational, zero cycles.
// Backpressure: none; result follows inputs continuously.
module alu_shifter
    import alu_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] amt,
    input  logic [1:0]   fn,
    output logic [W-1:0] res
);

    logic           big;
    logic [2:0]     sh;
    logic [2*W-1:0] rot_wide;
    logic [W-1:0]   sra_res;

    // Any amount of 8 or more empties the word for SLL/SRL and fills it with the sign for SRA.
    assign big      = |amt[W-1:3];
    assign sh       = amt[2:0];
    assign rot_wide = {a, a} << sh;
    assign sra_res  = W'($signed(a) >>> sh);

    always_comb begin
        res = a;
        unique case (fn)
            F_SLL: res = big ? '0 : (a << sh);
            F_SRL: res = big ? '0 : (a >> sh);
            F_SRA: res = big ? {W{a[W-1]}} : sra_res;
            F_ROL: res = rot_wide[2*W-1:W];
            default: res = a;
        endcase
    end

endmodule

// File: rtl/alu.sv
// 8-bit ALU: add/logic/or-sub-compare/shift with combinational result and registered flags.
// Latency: Out/Zero/Carry combinational; ZeroQ/CarryQ one cycle after FlagEn.
// Backpressure: none; flags capture only when FlagEn is high, otherwise hold.
module alu
    import alu_pkg::*;
(
    input  logic         Clk,
    input  logic         Reset,
    input  logic [W-1:0] InputA,
    input  logic [W-1:0] InputB,
    input  logic [2:0]   OP,
    input  logic [1:0]   Function,
    input  logic         FlagEn,
    output logic [W-1:0] Out,
    output logic         Zero,
    output logic         Carry,
    output logic         ZeroQ,
    output logic         CarryQ
);

    logic         cin;
    logic [W:0]   sum9;
    logic [W:0]   diff9;
    logic [W-1:0] shift_res;
    alu_res_t     r;

    // Only add-with-carry consumes the registered carry.
    assign cin   = (Function == F_ADC) & CarryQ;
    assign sum9  = {1'b0, InputA} + {1'b0, InputB} + {{W{1'b0}}, cin};
    // Bit 8 of the 9-bit difference is set exactly when A < B (borrow).
    assign diff9 = {1'b0, InputA} - {1'b0, InputB};

    alu_shifter u_shifter (
        .a   (InputA),
        .amt (InputB),
        .fn  (Function),
        .res (shift_res)
    );

    always_comb begin
        r.res   = InputA;
        r.carry = 1'b0;
        unique case (OP)
            OP_ADD: begin
                r.res   = sum9[W-1:0];
                r.carry = sum9[W];
            end
            OP_LOGIC: begin
                unique case (Function)
                    F_AND:   r.res = InputA & InputB;
                    F_XOR:   r.res = InputA ^ InputB;
                    F_NOT:   r.res = ~InputA;
                    F_PASSB: r.res = InputB;
                    default: r.res = InputA;
                endcase
            end
            OP_ORSUB: begin
                unique case (Function)
                    F_OR:    r.res = InputA | InputB;
                    F_SUB: begin
                        r.res   = diff9[W-1:0];
                        r.carry = diff9[W];
                    end
                    F_SLT:   r.res = bool_to_word(diff9[W]);
                    F_SEQ:   r.res = bool_to_word(InputA == InputB);
                    default: r.res = InputA;
                endcase
            end
            OP_SHIFT: r.res = shift_res;
            default: begin
                r.res   = InputA;
                r.carry = 1'b0;
            end
        endcase
    end

    assign Out   = r.res;
    assign Carry = r.carry;
    assign Zero  = (r.res == '0);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ZeroQ  <= 1'b0;
            CarryQ <= 1'b0;
        end else if (FlagEn) begin
            ZeroQ  <= Zero;
            CarryQ <= Carry;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors per feature plus a random sweep against a bench model.
module tb_alu;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] ia = '0;
    logic [7:0] ib = '0;
    logic [2:0] iop = '0;
    logic [1:0] fn = '0;
    logic       FlagEn = 1'b0;
    logic [7:0] Out;
    logic       Zero, Carry, ZeroQ, CarryQ;

    int errors = 0;
    int checks = 0;
    logic mdl_cq = 1'b0;

    typedef struct packed {
        logic [7:0] out;
        logic       zero;
        logic       carry;
    } exp_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [1:0] f;
        logic [7:0] eo;
        logic       ec;
    } vec_t;

    exp_t sb[$];

    alu dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .InputA   (ia),
        .InputB   (ib),
        .OP       (iop),
        .Function (fn),
        .FlagEn   (FlagEn),
        .Out      (Out),
        .Zero     (Zero),
        .Carry    (Carry),
        .ZeroQ    (ZeroQ),
        .CarryQ   (CarryQ)
    );

    always #5 Clk = ~Clk;

    // Drive operands and record what the DUT should produce for them.
    task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input logic [1:0] f, input logic [7:0] eo, input logic ec);
        ia  = a;
        ib  = b;
        iop = op;
        fn  = f;
        sb.push_back('{eo, (eo == 8'h00), ec});
    endtask

    // Independent reference: integer arithmetic and bit-at-a-time shifting.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                                   input logic [1:0] f, input logic cq);
        int s;
        logic [7:0] r;
        logic c;
        r = a;
        c = 1'b0;
        if (op == 3'd0) begin
            s = int'(a) + int'(b) + ((f == 2'd1) ? int'(cq) : 0);
            r = 8'(s);
            c = (s > 255);
        end else if (op == 3'd1) begin
            case (f)
                2'd0: r = a & b;
                2'd1: r = a ^ b;
                2'd2: r = ~a;
                default: r = b;
            endcase
        end else if (op == 3'd2) begin
            case (f)
                2'd0: r = a | b;
                2'd1: begin s = int'(a) - int'(b); r = 8'(s); c = (s < 0); end
                2'd2: r = (a < b) ? 8'h01 : 8'h00;
                default: r = (a == b) ? 8'h01 : 8'h00;
            endcase
        end else if (op == 3'd3) begin
            case (f)
                2'd0: for (int k = 0; k < int'(b); k++) r = {r[6:0], 1'b0};
                2'd1: for (int k = 0; k < int'(b); k++) r = {1'b0, r[7:1]};
                2'd2: for (int k = 0; k < int'(b); k++) r = {r[7], r[7:1]};
                default: for (int k = 0; k < int'(b % 8); k++) r = {r[6:0], r[7]};
            endcase
        end
        return '{r, (r == 8'h00), c};
    endfunction

    task automatic test_reset;
        exp_t e;
        Reset  = 1'b1;
        FlagEn = 1'b1;
        apply(8'hFF, 8'h01, 3'b000, 2'b00, 8'h00, 1'b1);
        @(posedge Clk);
        #1;
        checks++;
        if (ZeroQ !== 1'b0 || CarryQ !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: zq=%b cq=%b, want 0 0", ZeroQ, CarryQ);
        end
        e = sb.pop_front();
        checks++;
        if ({Out, Zero, Carry} !== {e.out, e.zero, e.carry}) begin
            errors++;
            $display("FAIL reset_comb: out=%h z=%b c=%b, want out=%h z=%b c=%b", Out, Zero, Carry, e.out, e.zero, e.carry);
        end
        Reset  = 1'b0;
        FlagEn = 1'b0;
        mdl_cq = 1'b0;
    endtask

    task automatic test_add;
        vec_t v[$];
        exp_t e;
        v.push_back('{8'h01, 8'h01, 3'b000, 2'b00, 8'h02, 1'b0});
        v.push_back('{8'hC8, 8'h64, 3'b000, 2'b00, 8'h2C, 1'b1});
        v.push_back('{8'h10, 8'h20, 3'b000, 2'b10, 8'h30, 1'b0});
        v.push_back('{8'hF0, 8'h20, 3'b000, 2'b11, 8'h10, 1'b1});
        v.push_back('{8'h01, 8'h01, 3'b000, 2'b01, 8'h02, 1'b0});
        v.push_back('{8'hFF, 8'h01, 3'b000, 2'b00, 8'h00, 1'b1});
        foreach (v[i]) begin
            apply(v[i].a, v[i].b, v[i].op, v[i].f, v[i].eo, v[i].ec);
            #1;
            e = sb.pop_front();
            checks++;
            if ({Out, Zero, Carry} !== {e.out, e.zero, e.carry}) begin
                errors++;
                $display("FAIL add[%0d]: out=%h z=%b c=%b, want out=%h z=%b c=%b", i, Out, Zero, Carry, e.out, e.zero, e.carry);
            end
        end
        // Latch carry=1 from FF+1, then add-with-carry must include it.
        FlagEn = 1'b1;
        @(posedge Clk);
        #1;
        FlagEn = 1'b0;
        mdl_cq = 1'b1;
        checks++;
        if (CarryQ !== 1'b1) begin
            errors++;
            $display("FAIL add_carryq: cq=%b, want 1", CarryQ);
        end
        v.delete();
        v.push_back('{8'h01, 8'h01, 3'b000, 2'b01, 8'h03, 1'b0});
        v.push_back('{8'hFF, 8'h00, 3'b000, 2'b01, 8'h00, 1'b1});
        v.push_back('{8'h01, 8'h01, 3'b000, 2'b00, 8'h02, 1'b0});
        foreach (v[i]) begin
            apply(v[i].a, v[i].b, v[i].op, v[i].f, v[i].eo, v[i].ec);
            #1;
            e = sb.pop_front();
            checks++;
            if ({Out, Zero, Carry} !== {e.out, e.zero, e.carry}) begin
                errors++;
                $display("FAIL adc[%0d]: out=%h z=%b c=%b, want out=%h z=%b c=%b", i, Out, Zero, Carry, e.out, e.zero, e.carry);
            end
        end
    endtask

    task automatic test_logic;
        vec_t v[$];
        exp_t e;
        v.push_back('{8'hF0, 8'h3C, 3'b001, 2'b00, 8'h30, 1'b0});
        v.push_back('{8'hF0, 8'h3C, 3'b001, 2'b01, 8'hCC, 1'b0});
        v.push_back('{8'hF0, 8'h3C, 3'b001, 2'b10, 8'h0F, 1'b0});
        v.push_back('{8'hF0, 8'h3C, 3'b001, 2'b11, 8'h3C, 1'b0});
        v.push_back('{8'h0F, 8'hF0, 3'b001, 2'b00, 8'h00, 1'b0});
        foreach (v[i]) begin
            apply(v[i].a, v[i].b, v[i].op, v[i].f, v[i].eo, v[i].ec);
            #1;
            e = sb.pop_front();
            checks++;
            if ({Out, Zero, Carry} !== {e.out, e.zero, e.carry}) begin
                errors++;
                $display("FAIL logic[%0d]: out=%h z=%b c=%b, want out=%h z=%b c=%b", i, Out, Zero, Carry, e.out, e.zero, e.carry);
            end
        end
    endtask

    task automatic test_orsub;
        vec_t v[$];
        exp_t e;
        v.push_back('{8'h04, 8'h01, 3'b010, 2'b00, 8'h05, 1'b0});
        v.push_back('{8'h04, 8'h01, 3'b010, 2'b01, 8'h03, 1'b0});
        v.push_back('{8'h01, 8'h04, 3'b010, 2'b01, 8'hFD, 1'b1});
        v.push_back('{8'h01, 8'h04, 3'b010, 2'b10, 8'h01, 1'b0});
        v.push_back('{8'h04, 8'h01, 3'b010, 2'b10, 8'h00, 1'b0});
        v.push_back('{8'h05, 8'h05, 3'b010, 2'b11, 8'h01, 1'b0});
        v.push_back('{8'h05, 8'h06, 3'b010, 2'b11, 8'h00, 1'b0});
        foreach (v[i]) begin
            apply(v[i].a, v[i].b, v[i].op, v[i].f, v[i].eo, v[i].ec);
            #1;
            e = sb.pop_front();
            checks++;
            if ({Out, Zero, Carry} !== {e.out, e.zero, e.carry}) begin
                errors++;
                $display("FAIL orsub[%0d]: out=%h z=%b c=%b, want out=%h z=%b c=%b", i, Out, Zero, Carry, e.out, e.zero, e.carry);
            end
        end
    endtask

    task automatic test_shift;
        vec_t v[$];
        exp_t e;
        v.push_back('{8'h04, 8'h01, 3'b011, 2'b00, 8'h08, 1'b0});
        v.push_back('{8'h04, 8'h01, 3'b011, 2'b01, 8'h02, 1'b0});
        v.push_back('{8'h80, 8'h09, 3'b011, 2'b10, 8'hFF, 1'b0});
        v.push_back('{8'h80, 8'h03, 3'b011, 2'b10, 8'hF0, 1'b0});
        v.push_back('{8'h7F, 8'h08, 3'b011, 2'b10, 8'h00, 1'b0});
        v.push_back('{8'hFF, 8'h08, 3'b011, 2'b00, 8'h00, 1'b0});
        v.push_back('{8'hFF, 8'hC8, 3'b011, 2'b01, 8'h00, 1'b0});
        v.push_back('{8'hA5, 8'h01, 3'b011, 2'b11, 8'h4B, 1'b0});
        v.push_back('{8'hA5, 8'h09, 3'b011, 2'b11, 8'h4B, 1'b0});
        v.push_back('{8'hA5, 8'h00, 3'b011, 2'b00, 8'hA5, 1'b0});
        v.push_back('{8'hA5, 8'h00, 3'b011, 2'b01, 8'hA5, 1'b0});
        v.push_back('{8'hA5, 8'h00, 3'b011, 2'b10, 8'hA5, 1'b0});
        v.push_back('{8'hA5, 8'h00, 3'b011, 2'b11, 8'hA5, 1'b0});
        foreach (v[i]) begin
            apply(v[i].a, v[i].b, v[i].op, v[i].f, v[i].eo, v[i].ec);
            #1;
            e = sb.pop_front();
            checks++;
            if ({Out, Zero, Carry} !== {e.out, e.zero, e.carry}) begin
                errors++;
                $display("FAIL shift[%0d]: out=%h z=%b c=%b, want out=%h z=%b c=%b", i, Out, Zero, Carry, e.out, e.zero, e.carry);
            end
        end
    endtask

    task automatic test_reserved;
        vec_t v[$];
        exp_t e;
        v.push_back('{8'h3C, 8'hFF, 3'b100, 2'b00, 8'h3C, 1'b0});
        v.push_back('{8'h3C, 8'hFF, 3'b101, 2'b01, 8'h3C, 1'b0});
        v.push_back('{8'hFF, 8'hFF, 3'b110, 2'b10, 8'hFF, 1'b0});
        v.push_back('{8'h00, 8'hFF, 3'b111, 2'b11, 8'h00, 1'b0});
        foreach (v[i]) begin
            apply(v[i].a, v[i].b, v[i].op, v[i].f, v[i].eo, v[i].ec);
            #1;
            e = sb.pop_front();
            checks++;
            if ({Out, Zero, Carry} !== {e.out, e.zero, e.carry}) begin
                errors++;
                $display("FAIL reserved[%0d]: out=%h z=%b c=%b, want out=%h z=%b c=%b", i, Out, Zero, Carry, e.out, e.zero, e.carry);
            end
        end
    endtask

    task automatic test_flags;
        exp_t e;
        vec_t v[3];
        logic [1:0] want_q[3];
        logic en[3];
        v[0] = '{8'h05, 8'h05, 3'b010, 2'b01, 8'h00, 1'b0};
        v[1] = '{8'hFF, 8'h01, 3'b000, 2'b00, 8'h00, 1'b1};
        v[2] = '{8'h01, 8'h01, 3'b000, 2'b00, 8'h02, 1'b0};
        en[0] = 1'b1; want_q[0] = 2'b10;
        en[1] = 1'b1; want_q[1] = 2'b11;
        en[2] = 1'b0; want_q[2] = 2'b11;
        for (int i = 0; i < 3; i++) begin
            apply(v[i].a, v[i].b, v[i].op, v[i].f, v[i].eo, v[i].ec);
            #1;
            e = sb.pop_front();
            checks++;
            if ({Out, Zero, Carry} !== {e.out, e.zero, e.carry}) begin
                errors++;
                $display("FAIL flags_comb[%0d]: out=%h z=%b c=%b, want out=%h z=%b c=%b", i, Out, Zero, Carry, e.out, e.zero, e.carry);
            end
            FlagEn = en[i];
            @(posedge Clk);
            #1;
            FlagEn = 1'b0;
            checks++;
            if ({ZeroQ, CarryQ} !== want_q[i]) begin
                errors++;
                $display("FAIL flags_q[%0d]: zq,cq=%b, want %b", i, {ZeroQ, CarryQ}, want_q[i]);
            end
        end
        mdl_cq = 1'b1;
    endtask

    task automatic test_reset_flags;
        exp_t e;
        Reset  = 1'b1;
        FlagEn = 1'b1;
        apply(8'h12, 8'h34, 3'b001, 2'b01, 8'h26, 1'b0);
        @(posedge Clk);
        #1;
        checks++;
        if (ZeroQ !== 1'b0 || CarryQ !== 1'b0) begin
            errors++;
            $display("FAIL rst_after_flags: zq=%b cq=%b, want 0 0", ZeroQ, CarryQ);
        end
        e = sb.pop_front();
        checks++;
        if ({Out, Zero, Carry} !== {e.out, e.zero, e.carry}) begin
            errors++;
            $display("FAIL rst_comb_a: out=%h z=%b c=%b, want out=%h z=%b c=%b", Out, Zero, Carry, e.out, e.zero, e.carry);
        end
        // Inputs change while reset is still asserted; outputs must follow.
        apply(8'hFF, 8'h02, 3'b000, 2'b00, 8'h01, 1'b1);
        #1;
        e = sb.pop_front();
        checks++;
        if ({Out, Zero, Carry} !== {e.out, e.zero, e.carry}) begin
            errors++;
            $display("FAIL rst_comb_b: out=%h z=%b c=%b, want out=%h z=%b c=%b", Out, Zero, Carry, e.out, e.zero, e.carry);
        end
        Reset  = 1'b0;
        FlagEn = 1'b0;
        mdl_cq = 1'b0;
    endtask

    task automatic test_random;
        exp_t e;
        exp_t m;
        logic [7:0] a, b;
        logic [2:0] op;
        logic [1:0] f;
        for (int i = 0; i < 300; i++) begin
            a  = 8'($urandom_range(0, 255));
            b  = (i % 3 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 10));
            op = 3'($urandom_range(0, 7));
            f  = 2'($urandom_range(0, 3));
            m  = model(a, b, op, f, mdl_cq);
            apply(a, b, op, f, m.out, m.carry);
            #1;
            e = sb.pop_front();
            checks++;
            if ({Out, Zero, Carry} !== {e.out, e.zero, e.carry}) begin
                errors++;
                $display("FAIL random[%0d] a=%h b=%h op=%0d f=%0d: out=%h z=%b c=%b, want out=%h z=%b c=%b",
                         i, a, b, op, f, Out, Zero, Carry, e.out, e.zero, e.carry);
            end
            if (i % 8 == 7) begin
                FlagEn = 1'b1;
                @(posedge Clk);
                #1;
                FlagEn = 1'b0;
                mdl_cq = m.carry;
                checks++;
                if ({ZeroQ, CarryQ} !== {m.zero, m.carry}) begin
                    errors++;
                    $display("FAIL random_q[%0d]: zq,cq=%b, want %b", i, {ZeroQ, CarryQ}, {m.zero, m.carry});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_logic();
        test_orsub();
        test_shift();
        test_reserved();
        test_flags();
        test_reset_flags();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Clk  input  1  single clock; all registered state updates on rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset, sampled on rising Clk.
REQ-003 InputA  input  8  operand A, unsigned.
REQ-004 InputB  input  8  operand B, unsigned; also the shift amount.
REQ-005 OP  input  3  operation class.
REQ-006 Function  input  2  sub-operation select within OP.
REQ-007 Out  output  8  combinational result.
REQ-008 Zero  output  1  combinational; 1 when Out == 8'h00.
REQ-009 Carry  output  1  combinational; carry or borrow of ADD/SUB, else 0.
REQ-010 FlagEn  input  1  when 1, the flag registers capture on the clock edge.
REQ-011 ZeroQ, CarryQ  output  1 each  registered copies of Zero and Carry.

Function
REQ-012 Out, Zero and Carry SHALL be purely combinational from InputA/InputB/OP/Function (zero latency), valid within one time unit of any input change, independent of Clk and Reset.
REQ-013 OP=000: F=00 Out=A+B (mod 256), Carry=bit 8 of the sum; F=01 Out=A+B+CarryQ, Carry=bit 8 of the sum; F=1x Out=A+B, Carry=bit 8 of the sum.
REQ-014 OP=001: F=00 A&B; F=01 A^B; F=10 ~A; F=11 pass B.
REQ-015 OP=010: F=00 A|B; F=01 A-B (mod 256), Carry=1 iff A<B (borrow); F=10 Out=8'h01 if A<B unsigned else 8'h00; F=11 Out=8'h01 if A==B else 8'h00.
REQ-016 OP=011: F=00 A<<B (logical); F=01 A>>B (logical); F=10 arithmetic right shift of A by B; F=11 rotate A left by B[2:0].
REQ-017 Shift boundary: for B>=8, SLL/SRL SHALL give 8'h00; SRA SHALL give 8'hFF if A[7]=1, else 8'h00; B=0 SHALL pass A unchanged for all shifts and the rotate.
REQ-018 OP=1xx (reserved): Out=InputA, Carry=0.
REQ-019 Carry SHALL be 0 for every operation not listed in REQ-013/REQ-015.
REQ-020 Zero SHALL reflect the final Out of every operation, including the compare results.
REQ-021 On a rising Clk edge with Reset=0 and FlagEn=1: ZeroQ<=Zero, CarryQ<=Carry; with FlagEn=0 both hold.

Reset
REQ-022 With Reset=1 at a rising Clk edge, ZeroQ and CarryQ SHALL become 0, overriding FlagEn.
REQ-023 Reset SHALL NOT affect the combinational outputs Out, Zero and Carry.

Structure
REQ-024 The OP encodings (ADD, LOGIC, ORSUB, SHIFT) and the Function encodings SHALL be localparams in a shared package, alu_pkg, used by the ALU and the decoder.
REQ-025 One sub-module, alu_shifter (covering SLL/SRL/SRA/ROL), is natural; all other logic SHALL reside in alu.

Verification
REQ-026 A=1, B=1, OP=000, F=00 -> Out=8'h02, Zero=0, Carry=0.
REQ-027 A=4, B=1, OP=010, F=00 -> Out=8'h05; then F=01 -> Out=8'h03, Carry=0.
REQ-028 A=4, B=1, OP=011, F=00 -> Out=8'h08; F=01 -> Out=8'h02; A=8'h80, B=9, F=10 -> Out=8'hFF.
REQ-029 A=5, B=5, OP=010, F=01 -> Out=8'h00, Zero=1; clock with FlagEn=1 -> ZeroQ=1; A=8'hFF, B=1, OP=000, F=00 -> Out=8'h00, Carry=1.
REQ-030 Reset=1 for one Clk edge after REQ-029 -> ZeroQ=0, CarryQ=0, while Out still tracks the inputs combinationally.
